shift_reg_univ: RTL and testbench

SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

---
 rtl/shift_reg_pkg.sv | 13 +
 rtl/tick_gen.sv | 39 +++
 rtl/shift_reg_univ.sv | 82 ++++++++
 tb/tb_shift_reg_univ.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared mode encodings and default prescaler divide for the universal shift register.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    SHL = 2'b00,
    SHR = 2'b01,
    ROL = 2'b10,
    ROR = 2'b11
  } mode_e;

  localparam int TICK_DIV_DEF = 33554432;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: TICK is a registered one-cycle pulse every TICK_DIV cycles.
// The pulse appears in the cycle after the counter sits at TICK_DIV-1; reset discards the partial count.
module tick_gen
  import shift_reg_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic CLK,
  input  logic R_N,
  output logic TICK
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          wrap;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    tick_d = wrap;
  end

  always_ff @(posedge CLK) begin
    if (!R_N) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign TICK = tick_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift/rotate register with parallel load, tick-qualified stepping and a saturating step count.
// All state is registered; a load or step takes effect at the edge it is presented, LOAD beats a step.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic                       CLK,
  input  logic                       R_N,
  input  logic                       CE,
  input  logic [1:0]                 MODE,
  input  logic                       SLI,
  input  logic                       SRI,
  input  logic                       LOAD,
  input  logic [WIDTH-1:0]           D,
  output logic [WIDTH-1:0]           Q,
  output logic                       SLO,
  output logic                       SRO,
  output logic                       TICK,
  output logic [$clog2(WIDTH+1)-1:0] SCNT,
  output logic                       FULL
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam logic [SW-1:0] SMAX = SW'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  logic             full_q, full_d;
  logic             tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .CLK (CLK),
    .R_N (R_N),
    .TICK(tick)
  );

  always_comb begin
    q_d    = q_q;
    scnt_d = scnt_q;
    full_d = full_q;
    if (LOAD) begin
      q_d    = D;
      scnt_d = '0;
      full_d = 1'b0;
    end else if (CE && tick) begin
      case (mode_e'(MODE))
        SHL:     q_d = {q_q[WIDTH-2:0], SLI};
        SHR:     q_d = {SRI, q_q[WIDTH-1:1]};
        ROL:     q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        ROR:     q_d = {q_q[0], q_q[WIDTH-1:1]};
        default: q_d = q_q;
      endcase
      // Count saturates so FULL stays asserted after WIDTH or more steps.
      if (scnt_q != SMAX) scnt_d = scnt_q + 1'b1;
      full_d = (scnt_d == SMAX);
    end
  end

  always_ff @(posedge CLK) begin
    if (!R_N) begin
      q_q    <= '0;
      scnt_q <= '0;
      full_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      scnt_q <= scnt_d;
      full_q <= full_d;
    end
  end

  assign Q    = q_q;
  assign SLO  = q_q[WIDTH-1];
  assign SRO  = q_q[0];
  assign TICK = tick;
  assign SCNT = scnt_q;
  assign FULL = full_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: directed vector table plus randomized run against a behavioural model.
module tb_shift_reg_univ;

  logic       clk = 1'b0;
  logic       r_n = 1'b0;
  logic       ce = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       sli = 1'b0;
  logic       sri = 1'b0;
  logic       load = 1'b0;
  logic [7:0] d = 8'h00;

  logic [7:0] q4, q1;
  logic       slo4, sro4, tick4, full4;
  logic       slo1, sro1, tick1, full1;
  logic [3:0] scnt4, scnt1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(8), .TICK_DIV(4)) dut4 (
    .CLK(clk), .R_N(r_n), .CE(ce), .MODE(mode), .SLI(sli), .SRI(sri),
    .LOAD(load), .D(d), .Q(q4), .SLO(slo4), .SRO(sro4), .TICK(tick4),
    .SCNT(scnt4), .FULL(full4)
  );

  shift_reg_univ #(.WIDTH(8), .TICK_DIV(1)) dut1 (
    .CLK(clk), .R_N(r_n), .CE(ce), .MODE(mode), .SLI(sli), .SRI(sri),
    .LOAD(load), .D(d), .Q(q1), .SLO(slo1), .SRO(sro1), .TICK(tick1),
    .SCNT(scnt1), .FULL(full1)
  );

  // Behavioural model, index 0 -> TICK_DIV=4 instance, index 1 -> TICK_DIV=1 instance.
  int m_q[2], m_pres[2], m_tick[2], m_scnt[2], m_full[2];
  int m_div[2] = '{4, 1};

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!r_n) begin
        m_q[k] = 0; m_pres[k] = 0; m_tick[k] = 0; m_scnt[k] = 0; m_full[k] = 0;
      end else begin
        if (load) begin
          m_q[k] = d; m_scnt[k] = 0; m_full[k] = 0;
        end else if (ce && m_tick[k] == 1) begin
          case (mode)
            2'd0: m_q[k] = ((m_q[k] * 2) + sli) % 256;
            2'd1: m_q[k] = (m_q[k] / 2) + (sri ? 128 : 0);
            2'd2: m_q[k] = ((m_q[k] * 2) % 256) + (m_q[k] / 128);
            default: m_q[k] = (m_q[k] / 2) + ((m_q[k] % 2) * 128);
          endcase
          m_scnt[k] = (m_scnt[k] + 1 > 8) ? 8 : m_scnt[k] + 1;
          m_full[k] = (m_scnt[k] == 8) ? 1 : 0;
        end
        m_tick[k] = (m_pres[k] == m_div[k] - 1) ? 1 : 0;
        m_pres[k] = (m_pres[k] + 1) % m_div[k];
      end
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pack_out(input int k);
    logic [15:0] v;
    if (k == 0) v = {q4, slo4, sro4, tick4, scnt4, full4};
    else        v = {q1, slo1, sro1, tick1, scnt1, full1};
    return int'(v);
  endfunction

  function automatic int pack_model(input int k);
    logic [7:0] mq;
    logic [3:0] ms;
    logic [15:0] v;
    mq = 8'(m_q[k]);
    ms = 4'(m_scnt[k]);
    v  = {mq, mq[7], mq[0], 1'(m_tick[k]), ms, 1'(m_full[k])};
    return int'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!tick4 && n < 10) begin
      step();
      n++;
    end
    check("wait_tick", int'(tick4), 1);
  endtask

  typedef struct {
    logic       ld;
    logic [7:0] dd;
    logic       ce;
    logic [1:0] md;
    logic       sl;
    logic       sr;
    logic [7:0] eq;
    int         es;
    logic       ef;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic ld_i, input logic [7:0] d_i, input logic ce_i,
                     input logic [1:0] md_i, input logic sl_i, input logic sr_i,
                     input logic [7:0] eq_i, input int es_i, input logic ef_i);
    vec_t v;
    v.ld = ld_i; v.dd = d_i; v.ce = ce_i; v.md = md_i; v.sl = sl_i; v.sr = sr_i;
    v.eq = eq_i; v.es = es_i; v.ef = ef_i;
    vt.push_back(v);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] eqv;
    int n;

    // Shift-left pattern 1,0,1,1,0,0,1,0 and saturation
    add(0, 8'h00, 1, 2'd0, 1, 0, 8'h01, 1, 0);
    add(0, 8'h00, 1, 2'd0, 0, 0, 8'h02, 2, 0);
    add(0, 8'h00, 1, 2'd0, 1, 0, 8'h05, 3, 0);
    add(0, 8'h00, 1, 2'd0, 1, 0, 8'h0B, 4, 0);
    add(0, 8'h00, 1, 2'd0, 0, 0, 8'h16, 5, 0);
    add(0, 8'h00, 1, 2'd0, 0, 0, 8'h2C, 6, 0);
    add(0, 8'h00, 1, 2'd0, 1, 0, 8'h59, 7, 0);
    add(0, 8'h00, 1, 2'd0, 0, 0, 8'hB2, 8, 1);
    add(0, 8'h00, 1, 2'd0, 0, 0, 8'h64, 8, 1);
    add(0, 8'h00, 0, 2'd0, 1, 1, 8'h64, 8, 1);
    // Load then rotates
    add(1, 8'h81, 0, 2'd2, 0, 0, 8'h81, 0, 0);
    add(0, 8'h00, 1, 2'd2, 0, 0, 8'h03, 1, 0);
    add(0, 8'h00, 1, 2'd3, 0, 0, 8'h81, 2, 0);
    add(0, 8'h00, 1, 2'd3, 0, 0, 8'hC0, 3, 0);
    // Load coincident with a qualifying tick wins
    add(1, 8'h5A, 1, 2'd0, 1, 1, 8'h5A, 0, 0);
    // Shift-right with SRI=1 from zero
    add(1, 8'h00, 0, 2'd1, 0, 1, 8'h00, 0, 0);
    add(0, 8'h00, 1, 2'd1, 0, 1, 8'h80, 1, 0);
    add(0, 8'h00, 1, 2'd1, 0, 1, 8'hC0, 2, 0);
    add(0, 8'h00, 1, 2'd1, 0, 1, 8'hE0, 3, 0);

    // Reset and idle: TICK every 4 cycles, first on the 4th edge after release
    r_n = 1'b0;
    step();
    step();
    check("reset_state4", pack_out(0), 0);
    r_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      check("idle_tick", int'(tick4), (i % 4 == 0) ? 1 : 0);
      check("idle_model4", pack_out(0), pack_model(0));
    end
    check("idle_q", int'(q4), 0);
    check("idle_scnt", int'(scnt4), 0);

    // Table: each record is presented at a qualifying tick
    for (int i = 0; i < vt.size(); i++) begin
      wait_tick();
      load = vt[i].ld; d = vt[i].dd; ce = vt[i].ce; mode = vt[i].md;
      sli = vt[i].sl; sri = vt[i].sr;
      step();
      load = 1'b0; ce = 1'b0;
      eqv = vt[i].eq;
      check($sformatf("vec%0d_q", i), int'(q4), int'(eqv));
      check($sformatf("vec%0d_scnt", i), int'(scnt4), vt[i].es);
      check($sformatf("vec%0d_full", i), int'(full4), int'(vt[i].ef));
      check($sformatf("vec%0d_slo_sro", i), int'({slo4, sro4}), int'({eqv[7], eqv[0]}));
      check($sformatf("vec%0d_model", i), pack_out(0), pack_model(0));
    end

    // Reset right after the third shift-right tick
    r_n = 1'b0;
    step();
    check("rst_all_zero4", pack_out(0), 0);
    check("rst_all_zero1", pack_out(1), 0);
    r_n = 1'b1;
    n = 0;
    while (!tick4 && n < 10) begin
      step();
      n++;
    end
    check("rst_first_tick_delay", n, 4);

    // TICK_DIV=1 instance: shifts on every CE cycle
    r_n = 1'b0;
    step();
    r_n = 1'b1;
    step();
    check("div1_tick_on", int'(tick1), 1);
    pat = 8'b1011_0010;
    ce = 1'b1; mode = 2'd0;
    for (int i = 7; i >= 0; i--) begin
      sli = pat[i];
      step();
    end
    ce = 1'b0;
    check("div1_q", int'(q1), 8'hB2);
    check("div1_scnt", int'(scnt1), 8);
    check("div1_full", int'(full1), 1);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      r_n  = ($urandom_range(0, 63) != 0);
      load = ($urandom_range(0, 15) == 0);
      ce   = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      sli  = 1'($urandom_range(0, 1));
      sri  = 1'($urandom_range(0, 1));
      d    = 8'($urandom_range(0, 255));
      step();
      check("rand_model4", pack_out(0), pack_model(0));
      check("rand_model1", pack_out(1), pack_model(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
